// File: rtl/seq_booth_multiplier.sv
// Iterative radix-2 Booth multiplier: one Booth step per cycle, registered result
// held until the next accepted start, one-cycle done pulse.
module seq_booth_multiplier #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned OUT_W = 64
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [OUT_W-1:0] o_c,
    output logic             o_done,
    output logic             o_busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] c_q, c_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   m_ext_c;
    logic [WIDTH:0]   a_sum_c;
    logic [WIDTH:0]   a_sh_c;
    logic [WIDTH-1:0] q_sh_c;

    // One Booth step: conditional add/subtract of M, then arithmetic shift of {A,Q,q_m1}
    always_comb begin
        m_ext_c = {m_q[WIDTH-1], m_q};
        case ({q_q[0], qm1_q})
            2'b01:   a_sum_c = a_q + m_ext_c;
            2'b10:   a_sum_c = a_q - m_ext_c;
            default: a_sum_c = a_q;
        endcase
        a_sh_c = {a_sum_c[WIDTH], a_sum_c[WIDTH:1]};
        q_sh_c = {a_sum_c[0], q_q[WIDTH-1:1]};
    end

    // Next-state and datapath control for IDLE / BUSY / DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        done_d  = 1'b0;
        busy_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d = ST_BUSY;
                    busy_d  = 1'b1;
                    m_d     = i_a;
                    q_d     = i_b;
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                busy_d = 1'b1;
                a_d    = a_sh_c;
                q_d    = q_sh_c;
                qm1_d  = q_q[0];
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Last step: publish the low product bits on the edge entering DONE
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    c_d     = OUT_W'({a_sh_c, q_sh_c});
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign o_c    = c_q;
    assign o_done = done_q;
    assign o_busy = busy_q;

endmodule
